multicycle_control: RTL and testbench

Multicycle sequencer for the single-cycle MIPS-subset datapath (register file, extender, 8-function ALU, data memory). It replaces the purely combinational decoder so that instruction fetch, register read, ALU, memory access and write-back share one clock over several cycles. The controller has a handshake with instruction and data memory so that it can stall on slow memories. It emits the same control strobes the datapath already consumes, plus PC/IR write enables and a retire pulse.

---
 rtl/multicycle_control_pkg.sv | 95 +++++++++
 rtl/mc_decode.sv | 38 +++
 rtl/multicycle_control.sv | 152 +++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS-subset sequencer:
// state encoding, opcode/funct fields, ALUctr codes and the latched instruction class.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_ADDU = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  // R-type keeps its function so the ALU code can be recovered after DECODE
  typedef enum logic [3:0] {
    C_ADD     = 4'd0,
    C_ADDU    = 4'd1,
    C_SUB     = 4'd2,
    C_SUBU    = 4'd3,
    C_AND     = 4'd4,
    C_OR      = 4'd5,
    C_SLL     = 4'd6,
    C_SLT     = 4'd7,
    C_SLTU    = 4'd8,
    C_ADDI    = 4'd9,
    C_LW      = 4'd10,
    C_SW      = 4'd11,
    C_BEQ     = 4'd12,
    C_BNE     = 4'd13,
    C_BGTZ    = 4'd14,
    C_ILLEGAL = 4'd15
  } class_e;

  function automatic logic [2:0] alu_of_class(input class_e c);
    case (c)
      C_ADD:                 return ALU_ADD;
      C_ADDU:                return ALU_ADDU;
      C_SUB, C_SUBU:         return ALU_SUB;
      C_AND:                 return ALU_AND;
      C_OR:                  return ALU_OR;
      C_SLL:                 return ALU_SLL;
      C_SLT:                 return ALU_SLT;
      C_SLTU:                return ALU_SLTU;
      C_ADDI, C_LW, C_SW:    return ALU_ADD;
      C_BEQ, C_BNE, C_BGTZ:  return ALU_SUB;
      default:               return ALU_AND;
    endcase
  endfunction

  function automatic logic is_rtype(input class_e c);
    return (c <= C_SLTU);
  endfunction

  function automatic logic is_branch(input class_e c);
    return (c == C_BEQ) || (c == C_BNE) || (c == C_BGTZ);
  endfunction

  function automatic logic uses_imm(input class_e c);
    return (c == C_ADDI) || (c == C_LW) || (c == C_SW);
  endfunction

  function automatic logic branch_taken(input class_e c, input logic equal, input logic sign);
    return ((c == C_BEQ)  &&  equal) ||
           ((c == C_BNE)  && !equal) ||
           ((c == C_BGTZ) && !(equal | sign));
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/fun -> instruction class mapping; registered by the top in DECODE.
module mc_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fun,
  output class_e     cls
);

  // Map opcode, and for R-type the function field, onto a class
  always_comb begin
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fun)
          FN_ADD:  cls = C_ADD;
          FN_ADDU: cls = C_ADDU;
          FN_SUB:  cls = C_SUB;
          FN_SUBU: cls = C_SUBU;
          FN_AND:  cls = C_AND;
          FN_OR:   cls = C_OR;
          FN_SLL:  cls = C_SLL;
          FN_SLT:  cls = C_SLT;
          FN_SLTU: cls = C_SLTU;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: cls = C_ADDI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_BGTZ: cls = C_BGTZ;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer with imem/dmem ready handshakes for the MIPS-subset datapath.
// Define MULTICYCLE_CONTROL_TRAP_EN to send illegal instructions to a sticky TRAP state.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  input  logic       equal,
  input  logic       sign,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       nPC_sel,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ExtOp,
  output logic       ALUSrc,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic       mem_rd,
  output logic [2:0] ALUctr,
  output logic       instr_done,
  output logic       trap,
  output logic [2:0] state
);

  state_e state_r;
  state_e state_nx_s;
  class_e class_r;
  class_e dec_class_s;

  mc_decode u_decode (
    .op  (op),
    .fun (fun),
    .cls (dec_class_s)
  );

  // State and class registers; class is captured only while in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      class_r <= C_ILLEGAL;
    end else begin
      state_r <= state_nx_s;
      if (state_r == S_DECODE) begin
        class_r <= dec_class_s;
      end else begin
        class_r <= class_r;
      end
    end
  end

  // Next state and output decode; every output is forced low while rst is high
  always_comb begin
    state_nx_s = state_r;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    nPC_sel    = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ExtOp      = 1'b0;
    ALUSrc     = 1'b0;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    mem_rd     = 1'b0;
    ALUctr     = 3'd0;
    instr_done = 1'b0;
    trap       = 1'b0;
    state      = 3'd0;
    if (rst) begin
      state_nx_s = S_FETCH;
    end else begin
      state = state_r;
      case (state_r)
        S_FETCH: begin
          ir_wr = imem_ready;
          pc_wr = imem_ready;
          if (imem_ready) begin
            state_nx_s = S_DECODE;
          end else begin
            state_nx_s = S_FETCH;
          end
        end
        // Illegal handling must act in DECODE itself, before the class is latched
        S_DECODE: begin
          if (dec_class_s == C_ILLEGAL) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            trap       = 1'b1;
            state_nx_s = S_TRAP;
`else
            instr_done = 1'b1;
            state_nx_s = S_FETCH;
`endif
          end else begin
            state_nx_s = S_EXEC;
          end
        end
        S_EXEC: begin
          ALUctr = alu_of_class(class_r);
          ALUSrc = uses_imm(class_r);
          ExtOp  = uses_imm(class_r);
          RegDst = is_rtype(class_r);
          if (is_branch(class_r)) begin
            pc_wr      = branch_taken(class_r, equal, sign);
            nPC_sel    = branch_taken(class_r, equal, sign);
            instr_done = 1'b1;
            state_nx_s = S_FETCH;
          end else if ((class_r == C_LW) || (class_r == C_SW)) begin
            state_nx_s = S_MEM;
          end else begin
            state_nx_s = S_WB;
          end
        end
        S_MEM: begin
          mem_rd = (class_r == C_LW);
          MemWr  = (class_r == C_SW);
          if (!dmem_ready) begin
            state_nx_s = S_MEM;
          end else if (class_r == C_SW) begin
            instr_done = 1'b1;
            state_nx_s = S_FETCH;
          end else begin
            state_nx_s = S_WB;
          end
        end
        S_WB: begin
          RegWr      = 1'b1;
          MemtoReg   = (class_r == C_LW);
          RegDst     = is_rtype(class_r);
          ALUctr     = alu_of_class(class_r);
          instr_done = 1'b1;
          state_nx_s = S_FETCH;
        end
        S_TRAP: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          trap       = 1'b1;
          state_nx_s = S_TRAP;
`else
          state_nx_s = S_FETCH;
`endif
        end
        default: begin
          state_nx_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle compare of state,
// ALUctr and all strobes against hand-computed vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] fun;
  logic       equal;
  logic       sign;
  logic       imem_ready;
  logic       dmem_ready;
  logic       pc_wr, ir_wr, nPC_sel, RegWr, RegDst, ExtOp, ALUSrc;
  logic       MemWr, MemtoReg, mem_rd, instr_done, trap;
  logic [2:0] ALUctr;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [11:0] PCW  = 12'b1000_0000_0000;
  localparam logic [11:0] IRW  = 12'b0100_0000_0000;
  localparam logic [11:0] NPC  = 12'b0010_0000_0000;
  localparam logic [11:0] RW   = 12'b0001_0000_0000;
  localparam logic [11:0] RD   = 12'b0000_1000_0000;
  localparam logic [11:0] EXT  = 12'b0000_0100_0000;
  localparam logic [11:0] ASRC = 12'b0000_0010_0000;
  localparam logic [11:0] MW   = 12'b0000_0001_0000;
  localparam logic [11:0] M2R  = 12'b0000_0000_1000;
  localparam logic [11:0] MRD  = 12'b0000_0000_0100;
  localparam logic [11:0] DONE = 12'b0000_0000_0010;
  localparam logic [11:0] TRP  = 12'b0000_0000_0001;
  localparam logic [11:0] NONE = 12'b0000_0000_0000;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .fun        (fun),
    .equal      (equal),
    .sign       (sign),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .nPC_sel    (nPC_sel),
    .RegWr      (RegWr),
    .RegDst     (RegDst),
    .ExtOp      (ExtOp),
    .ALUSrc     (ALUSrc),
    .MemWr      (MemWr),
    .MemtoReg   (MemtoReg),
    .mem_rd     (mem_rd),
    .ALUctr     (ALUctr),
    .instr_done (instr_done),
    .trap       (trap),
    .state      (state)
  );

  always #5 clk = ~clk;

  logic [17:0] obs_s;
  assign obs_s = {state, ALUctr, pc_wr, ir_wr, nPC_sel, RegWr, RegDst, ExtOp,
                  ALUSrc, MemWr, MemtoReg, mem_rd, instr_done, trap};

  function automatic logic [17:0] ev(input logic [2:0] st, input logic [2:0] alu,
                                     input logic [11:0] f);
    return {st, alu, f};
  endfunction

  task automatic check_eq(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: compare mid-cycle, then advance to the next posedge+1
  task automatic cyc(input string tag, input logic [17:0] exp);
    #3;
    check_eq(tag, obs_s, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag);
    imem_ready = 1'b1;
    cyc({tag, "_fetch"}, ev(3'd0, 3'd0, PCW | IRW));
    cyc({tag, "_decode"}, ev(3'd1, 3'd0, NONE));
  endtask

  initial begin
    rst = 1'b1; op = 6'b000000; fun = 6'b000000; equal = 1'b0; sign = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #2;
    check_eq("rst_pre_edge", obs_s, ev(3'd0, 3'd0, NONE));
    @(posedge clk);
    #1;
    cyc("rst_hold", ev(3'd0, 3'd0, NONE));
    rst = 1'b0;

    // add
    op = 6'b000000; fun = 6'b100000;
    fetch_decode("add");
    cyc("add_exec", ev(3'd2, 3'd2, RD));
    cyc("add_wb", ev(3'd4, 3'd2, RW | RD | DONE));

    // lw with one imem wait and two dmem waits
    op = 6'b100011; fun = 6'b000000; imem_ready = 1'b0; dmem_ready = 1'b0;
    cyc("lw_fetch_wait", ev(3'd0, 3'd0, NONE));
    fetch_decode("lw");
    cyc("lw_exec", ev(3'd2, 3'd2, EXT | ASRC));
    cyc("lw_mem_w1", ev(3'd3, 3'd0, MRD));
    cyc("lw_mem_w2", ev(3'd3, 3'd0, MRD));
    dmem_ready = 1'b1;
    cyc("lw_mem_rdy", ev(3'd3, 3'd0, MRD));
    cyc("lw_wb", ev(3'd4, 3'd2, RW | M2R | DONE));

    // beq taken / not taken
    op = 6'b000100; equal = 1'b1;
    fetch_decode("beq_t");
    cyc("beq_t_exec", ev(3'd2, 3'd6, PCW | NPC | DONE));
    equal = 1'b0;
    fetch_decode("beq_nt");
    cyc("beq_nt_exec", ev(3'd2, 3'd6, DONE));

    // bne taken on !equal
    op = 6'b000101;
    fetch_decode("bne_t");
    cyc("bne_t_exec", ev(3'd2, 3'd6, PCW | NPC | DONE));

    // bgtz: negative not taken, positive taken
    op = 6'b000111; sign = 1'b1; equal = 1'b0;
    fetch_decode("bgtz_neg");
    cyc("bgtz_neg_exec", ev(3'd2, 3'd6, DONE));
    sign = 1'b0;
    fetch_decode("bgtz_pos");
    cyc("bgtz_pos_exec", ev(3'd2, 3'd6, PCW | NPC | DONE));

    // sub, sltu, all-zero word (sll), addi
    op = 6'b000000; fun = 6'b100010;
    fetch_decode("sub");
    cyc("sub_exec", ev(3'd2, 3'd6, RD));
    cyc("sub_wb", ev(3'd4, 3'd6, RW | RD | DONE));
    fun = 6'b101011;
    fetch_decode("sltu");
    cyc("sltu_exec", ev(3'd2, 3'd7, RD));
    cyc("sltu_wb", ev(3'd4, 3'd7, RW | RD | DONE));
    fun = 6'b000000;
    fetch_decode("sll0");
    cyc("sll0_exec", ev(3'd2, 3'd5, RD));
    cyc("sll0_wb", ev(3'd4, 3'd5, RW | RD | DONE));
    op = 6'b001000; fun = 6'b100000;
    fetch_decode("addi");
    cyc("addi_exec", ev(3'd2, 3'd2, EXT | ASRC));
    cyc("addi_wb", ev(3'd4, 3'd2, RW | DONE));

    // sw completes with one dmem wait
    op = 6'b101011; dmem_ready = 1'b0;
    fetch_decode("sw");
    cyc("sw_exec", ev(3'd2, 3'd2, EXT | ASRC));
    cyc("sw_mem_w", ev(3'd3, 3'd0, MW));
    dmem_ready = 1'b1;
    cyc("sw_mem_rdy", ev(3'd3, 3'd0, MW | DONE));

    // sw abandoned by reset in MEM, reset wins over dmem_ready
    dmem_ready = 1'b0;
    fetch_decode("sw_rst");
    cyc("sw_rst_exec", ev(3'd2, 3'd2, EXT | ASRC));
    #3;
    check_eq("sw_rst_mem", obs_s, ev(3'd3, 3'd0, MW));
    rst = 1'b1; dmem_ready = 1'b1;
    #1;
    check_eq("sw_rst_drop", obs_s, ev(3'd0, 3'd0, NONE));
    @(posedge clk);
    #1;
    rst = 1'b0; imem_ready = 1'b0;
    cyc("sw_rst_fetch", ev(3'd0, 3'd0, NONE));

    // illegal opcode
    op = 6'b111111; fun = 6'b000000;
    fetch_decode_illegal();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic fetch_decode_illegal();
    imem_ready = 1'b1;
    cyc("ill_fetch", ev(3'd0, 3'd0, PCW | IRW));
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    cyc("ill_decode", ev(3'd1, 3'd0, TRP));
    cyc("ill_trap1", ev(3'd5, 3'd0, TRP));
    cyc("ill_trap2", ev(3'd5, 3'd0, TRP));
    rst = 1'b1;
    cyc("ill_trap_rst", ev(3'd0, 3'd0, NONE));
    rst = 1'b0;
    cyc("ill_after_rst", ev(3'd0, 3'd0, PCW | IRW));
`else
    cyc("ill_decode", ev(3'd1, 3'd0, DONE));
    cyc("ill_next_fetch", ev(3'd0, 3'd0, PCW | IRW));
`endif
  endtask

endmodule
